// File: rtl/pixel_filt_if.sv
// Purpose : bundle of the filter-select inputs and colour-modifier outputs
//           exchanged between the video control logic and pixel_filt.
// Signals : filter_number [2:0]  filter select (0 normal, 1 brightness,
//                                2 siren, 3 convolution, 4-7 unused)
//           audio_pitch   [15:0] unsigned pitch measurement
//           r_mod/g_mod/b_mod [5:0] per-channel coefficient
//           div_flag             1 = divide by mod, 0 = multiply
// Modports: master drives filter/pitch, slave (pixel_filt) drives the mods.
interface pixel_filt_if;
  localparam int unsigned FILT_W  = 3;
  localparam int unsigned PITCH_W = 16;
  localparam int unsigned MOD_W   = 6;

  logic [FILT_W-1:0]  filter_number;
  logic [PITCH_W-1:0] audio_pitch;
  logic [MOD_W-1:0]   r_mod;
  logic [MOD_W-1:0]   g_mod;
  logic [MOD_W-1:0]   b_mod;
  logic               div_flag;

  modport master (
    output filter_number,
    output audio_pitch,
    input  r_mod,
    input  g_mod,
    input  b_mod,
    input  div_flag
  );

  modport slave (
    input  filter_number,
    input  audio_pitch,
    output r_mod,
    output g_mod,
    output b_mod,
    output div_flag
  );
endinterface

// File: rtl/pixel_filt.sv
// Purpose : per-frame colour-modifier generator. From the selected filter
//           and the current audio pitch it produces registered per-channel
//           multiply/divide coefficients for the downstream pixel datapath.
// Ports   : clk    - system clock, all updates on the rising edge
//           rst_n  - synchronous active-low reset (outputs go to identity)
//           pix    - pixel_filt_if.slave: filter_number, audio_pitch in;
//                    r_mod, g_mod, b_mod, div_flag out (1-cycle latency)
module pixel_filt #(
  parameter int unsigned BAND_WIDTH      = 43,
  parameter int unsigned SIREN_THRESHOLD = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  pixel_filt_if.slave  pix
);

  localparam int unsigned FILT_W  = 3;
  localparam int unsigned PITCH_W = 16;
  localparam int unsigned MOD_W   = 6;
  localparam int unsigned BAND_W  = 3;

  localparam logic [FILT_W-1:0] FILT_NORMAL = FILT_W'(0);
  localparam logic [FILT_W-1:0] FILT_BRIGHT = FILT_W'(1);
  localparam logic [FILT_W-1:0] FILT_SIREN  = FILT_W'(2);

  // Band thresholds: floor(pitch / BAND_WIDTH) without a divider.
  localparam logic [PITCH_W-1:0] TH1 = PITCH_W'(BAND_WIDTH * 1);
  localparam logic [PITCH_W-1:0] TH2 = PITCH_W'(BAND_WIDTH * 2);
  localparam logic [PITCH_W-1:0] TH3 = PITCH_W'(BAND_WIDTH * 3);
  localparam logic [PITCH_W-1:0] TH4 = PITCH_W'(BAND_WIDTH * 4);
  localparam logic [PITCH_W-1:0] TH5 = PITCH_W'(BAND_WIDTH * 5);
  localparam logic [PITCH_W-1:0] TH6 = PITCH_W'(BAND_WIDTH * 6);
  localparam logic [PITCH_W-1:0] SIREN_TH = PITCH_W'(SIREN_THRESHOLD);

  localparam logic [MOD_W-1:0] MOD_0 = MOD_W'(0);
  localparam logic [MOD_W-1:0] MOD_1 = MOD_W'(1);
  localparam logic [MOD_W-1:0] MOD_2 = MOD_W'(2);
  localparam logic [MOD_W-1:0] MOD_4 = MOD_W'(4);

  logic [BAND_W-1:0] band_c;
  logic [MOD_W-1:0]  r_mod_d, g_mod_d, b_mod_d;
  logic [MOD_W-1:0]  r_mod_q, g_mod_q, b_mod_q;
  logic              div_d, div_q;
  logic [MOD_W-1:0]  bright_mod_c;
  logic              bright_div_c;

  // Comparator chain; boundary values fall into the upper band, and
  // everything at or above the last threshold saturates at band 6.
  always_comb begin
    band_c = BAND_W'(0);
    if (pix.audio_pitch >= TH1) band_c = BAND_W'(1);
    if (pix.audio_pitch >= TH2) band_c = BAND_W'(2);
    if (pix.audio_pitch >= TH3) band_c = BAND_W'(3);
    if (pix.audio_pitch >= TH4) band_c = BAND_W'(4);
    if (pix.audio_pitch >= TH5) band_c = BAND_W'(5);
    if (pix.audio_pitch >= TH6) band_c = BAND_W'(6);
  end

  // Brightness coefficient per band (shared by all three channels).
  always_comb begin
    bright_mod_c = MOD_1;
    bright_div_c = 1'b0;
    case (band_c)
      BAND_W'(0): begin bright_mod_c = MOD_0; bright_div_c = 1'b0; end
      BAND_W'(1): begin bright_mod_c = MOD_4; bright_div_c = 1'b1; end
      BAND_W'(2): begin bright_mod_c = MOD_2; bright_div_c = 1'b1; end
      BAND_W'(3): begin bright_mod_c = MOD_1; bright_div_c = 1'b0; end
      BAND_W'(4): begin bright_mod_c = MOD_2; bright_div_c = 1'b0; end
      BAND_W'(5): begin bright_mod_c = MOD_4; bright_div_c = 1'b0; end
      default:    begin bright_mod_c = MOD_1; bright_div_c = 1'b0; end
    endcase
  end

  // Next coefficients from the current filter; unknown filters are identity.
  always_comb begin
    r_mod_d = MOD_1;
    g_mod_d = MOD_1;
    b_mod_d = MOD_1;
    div_d   = 1'b0;
    case (pix.filter_number)
      FILT_NORMAL: ;
      FILT_BRIGHT: begin
        r_mod_d = bright_mod_c;
        g_mod_d = bright_mod_c;
        b_mod_d = bright_mod_c;
        div_d   = bright_div_c;
      end
      FILT_SIREN: begin
        g_mod_d = MOD_0;
        if (pix.audio_pitch < SIREN_TH) begin
          r_mod_d = MOD_0;
          b_mod_d = MOD_1;
        end else begin
          r_mod_d = MOD_1;
          b_mod_d = MOD_0;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset forces identity and wins over any update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mod_q <= MOD_1;
      g_mod_q <= MOD_1;
      b_mod_q <= MOD_1;
      div_q   <= 1'b0;
    end else begin
      r_mod_q <= r_mod_d;
      g_mod_q <= g_mod_d;
      b_mod_q <= b_mod_d;
      div_q   <= div_d;
    end
  end

  assign pix.r_mod    = r_mod_q;
  assign pix.g_mod    = g_mod_q;
  assign pix.b_mod    = b_mod_q;
  assign pix.div_flag = div_q;

endmodule

// File: tb/tb_pixel_filt.sv
// Purpose : directed self-checking bench for pixel_filt. Each vector is
//           applied on the falling edge and checked 1 time unit after the
//           following rising edge against hand-computed coefficients.
module tb_pixel_filt;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pixel_filt_if pif ();

  pixel_filt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pix   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed value packed as {r, g, b, div}.
  logic [18:0] obs_c;
  assign obs_c = {pif.r_mod, pif.g_mod, pif.b_mod, pif.div_flag};

  function automatic logic [18:0] pk(input int r, input int g, input int b, input int d);
    pk = {6'(r), 6'(g), 6'(b), 1'(d)};
  endfunction

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got r=%0d g=%0d b=%0d div=%0d expected r=%0d g=%0d b=%0d div=%0d",
               tag, got[18:13], got[12:7], got[6:1], got[0],
               exp[18:13], exp[12:7], exp[6:1], exp[0]);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] f, input logic [15:0] p,
                      input logic [18:0] exp);
    @(negedge clk);
    pif.filter_number = f;
    pif.audio_pitch   = p;
    @(posedge clk);
    #1;
    chk(tag, obs_c, exp);
  endtask

  logic [18:0] bright_exp [8];
  int          bnd_pitch  [5];
  logic [18:0] bnd_exp    [5];

  initial begin
    checks = 0;
    errors = 0;
    bright_exp[0] = pk(0,0,0,0); bright_exp[1] = pk(0,0,0,0);
    bright_exp[2] = pk(4,4,4,1); bright_exp[3] = pk(2,2,2,1);
    bright_exp[4] = pk(1,1,1,0); bright_exp[5] = pk(2,2,2,0);
    bright_exp[6] = pk(4,4,4,0); bright_exp[7] = pk(1,1,1,0);
    bnd_pitch[0] = 42;    bnd_exp[0] = pk(0,0,0,0);
    bnd_pitch[1] = 43;    bnd_exp[1] = pk(4,4,4,1);
    bnd_pitch[2] = 257;   bnd_exp[2] = pk(4,4,4,0);
    bnd_pitch[3] = 258;   bnd_exp[3] = pk(1,1,1,0);
    bnd_pitch[4] = 65535; bnd_exp[4] = pk(1,1,1,0);

    // Reset held two cycles with brightness/pitch 0 applied.
    rst_n = 1'b0;
    pif.filter_number = 3'd1;
    pif.audio_pitch   = 16'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset", obs_c, pk(1,1,1,0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", obs_c, pk(0,0,0,0));

    for (int i = 0; i < 8; i++)
      step($sformatf("normal_p%0d", i*42), 3'd0, 16'(i*42), pk(1,1,1,0));

    for (int i = 0; i < 8; i++)
      step($sformatf("bright_p%0d", i*42), 3'd1, 16'(i*42), bright_exp[i]);

    for (int i = 0; i < 5; i++)
      step($sformatf("bright_bnd_p%0d", bnd_pitch[i]), 3'd1, 16'(bnd_pitch[i]), bnd_exp[i]);

    for (int i = 0; i < 7; i++) begin
      step("siren_blue", 3'd2, 16'd30,  pk(0,0,1,0));
      step("siren_red",  3'd2, 16'd150, pk(1,0,0,0));
    end
    step("siren_p127", 3'd2, 16'd127, pk(0,0,1,0));
    step("siren_p128", 3'd2, 16'd128, pk(1,0,0,0));

    for (int i = 1; i < 8; i++) begin
      step($sformatf("conv_p%0d", i*42),  3'd3, 16'(i*42), pk(1,1,1,0));
      step($sformatf("inval_p%0d", i*42), 3'd6, 16'(i*42), pk(1,1,1,0));
    end

    // Latency: filter 0 -> 1 at pitch 100 shows up after exactly one edge.
    step("lat_pre", 3'd0, 16'd100, pk(1,1,1,0));
    @(negedge clk);
    pif.filter_number = 3'd1;
    #4;
    chk("lat_before_edge", obs_c, pk(1,1,1,0));
    @(posedge clk);
    #1;
    chk("lat_after_edge", obs_c, pk(2,2,2,1));

    // Mid-operation reset overrides the pending brightness update.
    @(negedge clk);
    rst_n = 1'b0;
    pif.audio_pitch = 16'd200;
    @(posedge clk);
    #1;
    chk("reset_mid_op", obs_c, pk(1,1,1,0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_mid_reset", obs_c, pk(2,2,2,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_filt.md
Name: pixel_filt

Overview:
- Per-frame colour-modifier generator for the camera video path.
- Takes a selected filter number and the current audio pitch measurement.
- Produces per-channel multiplier/divisor coefficients (r_mod, g_mod, b_mod) plus a div_flag.
- A downstream pixel datapath applies them: each channel is multiplied by its mod when div_flag=0, or divided by it when div_flag=1.

Parameters:
- BAND_WIDTH, 43: pitch units per brightness band. Band index = audio_pitch / BAND_WIDTH.
- SIREN_THRESHOLD, 128: pitch boundary for the siren filter. Below = blue, at or above = red.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- filter_number, input, 3: filter select. 0 normal, 1 brightness, 2 police siren, 3 convolution (handled elsewhere), 4-7 unused.
- audio_pitch, input, 16: unsigned pitch value from the audio front end.
- r_mod, output, 6: red coefficient.
- g_mod, output, 6: green coefficient.
- b_mod, output, 6: blue coefficient.
- div_flag, output, 1: 1 = divide channels by their mod; 0 = multiply.

Behaviour:
- One clock, synchronous active-low reset.
- All outputs are registered. Inputs are sampled on the rising edge of clk and the result is visible after that edge (1-cycle latency).
- Reset (rst_n=0 at a rising edge): r_mod=g_mod=b_mod=1, div_flag=0 (identity). Reset mid-operation overrides any pending update on that edge.
- Band computation:
  - band = floor(audio_pitch / BAND_WIDTH).
  - Implemented as a comparator chain on thresholds 43, 86, 129, 172, 215, 258. No hardware divider.
  - Exact boundary values belong to the upper band (43 -> band 1, 258 -> band 6).
- filter 0 (normal): mods = 1,1,1; div_flag = 0. audio_pitch is ignored.
- filter 1 (brightness), all three mods equal:
  - band 0 (0..42): mod 0, div 0 (black).
  - band 1 (43..85): mod 4, div 1 (quarter brightness).
  - band 2 (86..128): mod 2, div 1 (half).
  - band 3 (129..171): mod 1, div 0 (unchanged).
  - band 4 (172..214): mod 2, div 0 (double).
  - band 5 (215..257): mod 4, div 0 (quadruple).
  - band >= 6 (>= 258, up to 65535): mod 1, div 0.
- filter 2 (siren):
  - audio_pitch < SIREN_THRESHOLD: r=0, g=0, b=1, div 0 (blue only).
  - audio_pitch >= SIREN_THRESHOLD: r=1, g=0, b=0, div 0 (red only).
- filter 3 (convolution): identity 1,1,1 / div 0. Convolution is done by another block.
- filter 4-7: identity 1,1,1 / div 0.
- Changing filter_number and audio_pitch on the same edge: the output reflects both new values after that edge. There is no internal history.
- Upper 3 bits of each mod are always 0 in this version. The 6-bit width is reserved for future coefficients.
- div_flag=1 never occurs with mod=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with filter=1, pitch=0 -> outputs 1,1,1, div 0. Release -> next edge gives 0,0,0, div 0.
- Normal: filter=0, pitch stepped 0, 42, 84, ... 294 -> every cycle outputs 1,1,1, div 0.
- Brightness sweep: filter=1, pitch = 0, 42, 84, 126, 168, 210, 252, 294.
  - Expected: 0/0, 0/0, 4/1, 2/1, 1/0, 2/0, 4/0, 1/0 (mod/div, all channels).
  - Boundary checks: 42 -> 0/0, 43 -> 4/1, 257 -> 4/0, 258 -> 1/0, 65535 -> 1/0.
- Siren: filter=2, alternate pitch 30 / 150 seven times -> (0,0,1,div 0) then (1,0,0,div 0). Pitch 127 -> blue; pitch 128 -> red.
- Convolution and invalid: filter=3 and filter=6, pitch 42..294 -> always 1,1,1, div 0.
- Latency: switch filter 0->1 with pitch=100 on one edge -> the change is visible exactly one cycle later as 2,2,2, div 1.
